// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: stall/flush decisions for load-use, taken branches and
// multi-cycle Execute ops, Execute-stage forwarding selects and a saturating stall counter.
module hazard_controller #(
    parameter int unsigned RegW = 4,
    parameter int unsigned CntW = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [RegW-1:0] rs1_d_i,
    input  logic [RegW-1:0] rs2_d_i,
    input  logic [RegW-1:0] rs1_e_i,
    input  logic [RegW-1:0] rs2_e_i,
    input  logic [RegW-1:0] rd_e_i,
    input  logic [RegW-1:0] rd_m_i,
    input  logic [RegW-1:0] rd_w_i,
    input  logic            mem_read_e_i,
    input  logic            reg_write_m_i,
    input  logic            reg_write_w_i,
    input  logic            pc_src_e_i,
    input  logic            mc_start_e_i,
    input  logic [CntW-1:0] mc_cycles_e_i,
    output logic            stall_f_o,
    output logic            stall_d_o,
    output logic            stall_e_o,
    output logic            flush_d_o,
    output logic            flush_e_o,
    output logic            flush_m_o,
    output logic [1:0]      forward_a_e_o,
    output logic [1:0]      forward_b_e_o,
    output logic [15:0]     stall_cnt_o
);

    typedef enum logic [0:0] {StRun, StMcWait} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [15:0]     stall_cnt_q, stall_cnt_d;

    logic lw_haz;
    logic mc_go;
    logic mc_hold;

    assign lw_haz = mem_read_e_i && (rd_e_i != '0) &&
                    ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i));
    assign mc_go  = (state_q == StRun) && mc_start_e_i && (mc_cycles_e_i > CntW'(1));
    // Hold covers both the launch cycle and every wait cycle except the release cycle.
    assign mc_hold = mc_go || ((state_q == StMcWait) && (cnt_q > CntW'(1)));

    // Stall/flush outputs are forced low while reset is asserted so an active
    // multi-cycle request cannot hold the pipeline during reset.
    always_comb begin
        stall_f_o = 1'b0;
        stall_d_o = 1'b0;
        stall_e_o = 1'b0;
        flush_d_o = 1'b0;
        flush_e_o = 1'b0;
        flush_m_o = 1'b0;
        if (rst_ni) begin
            if (mc_hold) begin
                stall_f_o = 1'b1;
                stall_d_o = 1'b1;
                stall_e_o = 1'b1;
                flush_m_o = 1'b1;
            end else begin
                stall_f_o = lw_haz;
                stall_d_o = lw_haz;
                flush_d_o = pc_src_e_i;
                flush_e_o = lw_haz || pc_src_e_i;
            end
        end
    end

    always_comb begin
        forward_a_e_o = 2'b00;
        if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs1_e_i)) begin
            forward_a_e_o = 2'b10;
        end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs1_e_i)) begin
            forward_a_e_o = 2'b01;
        end
    end

    always_comb begin
        forward_b_e_o = 2'b00;
        if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs2_e_i)) begin
            forward_b_e_o = 2'b10;
        end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs2_e_i)) begin
            forward_b_e_o = 2'b01;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StRun: begin
                if (mc_go) begin
                    state_d = StMcWait;
                    cnt_d   = mc_cycles_e_i - CntW'(1);
                end
            end
            StMcWait: begin
                if (cnt_q > CntW'(1)) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StRun;
                cnt_d   = '0;
            end
        endcase
    end

    assign stall_cnt_d = (stall_f_o && (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'd1
                                                                  : stall_cnt_q;
    assign stall_cnt_o = stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StRun;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller; inputs change on the falling edge
// and outputs are sampled 1 time unit later.
module tb_hazard_controller;

    logic        clk;
    logic        rst_n;
    logic [3:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic        mem_read_e, reg_write_m, reg_write_w, pc_src_e, mc_start_e;
    logic [3:0]  mc_cycles_e;
    logic        stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    hazard_controller #(.RegW(4), .CntW(4)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .rs1_d_i       (rs1_d),
        .rs2_d_i       (rs2_d),
        .rs1_e_i       (rs1_e),
        .rs2_e_i       (rs2_e),
        .rd_e_i        (rd_e),
        .rd_m_i        (rd_m),
        .rd_w_i        (rd_w),
        .mem_read_e_i  (mem_read_e),
        .reg_write_m_i (reg_write_m),
        .reg_write_w_i (reg_write_w),
        .pc_src_e_i    (pc_src_e),
        .mc_start_e_i  (mc_start_e),
        .mc_cycles_e_i (mc_cycles_e),
        .stall_f_o     (stall_f),
        .stall_d_o     (stall_d),
        .stall_e_o     (stall_e),
        .flush_d_o     (flush_d),
        .flush_e_o     (flush_e),
        .flush_m_o     (flush_m),
        .forward_a_e_o (fwd_a),
        .forward_b_e_o (fwd_b),
        .stall_cnt_o   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0;
        rd_e = 0; rd_m = 0; rd_w = 0;
        mem_read_e = 0; reg_write_m = 0; reg_write_w = 0;
        pc_src_e = 0; mc_start_e = 0; mc_cycles_e = 0;
    endtask

    // Next falling edge plus settle time.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mc_start_e = 1'b1; mc_cycles_e = 4'd5; pc_src_e = 1'b1;
        repeat (2) @(posedge clk);
        step();
        checks++;
        if ({stall_f, stall_d, stall_e, flush_d, flush_e, flush_m} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 000000",
                     {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m});
        end
        checks++;
        if (stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt);
        end
        // Release: launch cycle plus three wait cycles stall, then the release cycle.
        @(negedge clk);
        rst_n = 1'b1;
        pc_src_e = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({stall_f, stall_d, stall_e, flush_m} !== 4'b1111) begin
                errors++;
                $display("FAIL reset_release_stall[%0d] got %b want 1111", i,
                         {stall_f, stall_d, stall_e, flush_m});
            end
            step();
        end
        checks++;
        if ({stall_f, stall_e, flush_m} !== 3'b000) begin
            errors++;
            $display("FAIL reset_release_cycle got %b want 000", {stall_f, stall_e, flush_m});
        end
        checks++;
        if (stall_cnt !== 16'd4) begin
            errors++;
            $display("FAIL reset_release_cnt got %0d want 4", stall_cnt);
        end
        clear_inputs();
    endtask

    task automatic test_load_use();
        step();
        mem_read_e = 1'b1; rd_e = 4'd3; rs2_d = 4'd3;
        #1;
        checks++;
        if ({stall_f, stall_d, stall_e, flush_d, flush_e, flush_m} !== 6'b110010) begin
            errors++;
            $display("FAIL load_use got %b want 110010",
                     {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m});
        end
        step();
        clear_inputs();
        #1;
        checks++;
        if (stall_f !== 1'b0 || stall_cnt !== 16'd5) begin
            errors++;
            $display("FAIL load_use_after got stall_f=%b cnt=%0d want 0 and 5", stall_f, stall_cnt);
        end
        mem_read_e = 1'b1; rd_e = 4'd0; rs1_d = 4'd0;
        #1;
        checks++;
        if ({stall_f, flush_e} !== 2'b00) begin
            errors++;
            $display("FAIL load_use_r0 got %b want 00", {stall_f, flush_e});
        end
        step();
        clear_inputs();
        checks++;
        if (stall_cnt !== 16'd5) begin
            errors++;
            $display("FAIL load_use_r0_cnt got %0d want 5", stall_cnt);
        end
    endtask

    task automatic test_branch();
        pc_src_e = 1'b1;
        #1;
        checks++;
        if ({stall_f, stall_d, flush_d, flush_e, flush_m} !== 5'b00110) begin
            errors++;
            $display("FAIL branch got %b want 00110",
                     {stall_f, stall_d, flush_d, flush_e, flush_m});
        end
        step();
        clear_inputs();
        checks++;
        if (stall_cnt !== 16'd5) begin
            errors++;
            $display("FAIL branch_cnt got %0d want 5", stall_cnt);
        end
    endtask

    task automatic test_multicycle();
        mc_start_e = 1'b1; mc_cycles_e = 4'd4;
        pc_src_e = 1'b1;  // ignored on the launch cycle
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({stall_f, stall_d, stall_e, flush_d, flush_e, flush_m} !== 6'b111001) begin
                errors++;
                $display("FAIL mc_hold[%0d] got %b want 111001", i,
                         {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m});
            end
            step();
            pc_src_e = 1'b0;
        end
        checks++;
        if ({stall_f, stall_d, stall_e, flush_m} !== 4'b0000) begin
            errors++;
            $display("FAIL mc_release got %b want 0000", {stall_f, stall_d, stall_e, flush_m});
        end
        step();
        clear_inputs();
        checks++;
        if (stall_cnt !== 16'd8) begin
            errors++;
            $display("FAIL mc_cnt got %0d want 8", stall_cnt);
        end
        mc_start_e = 1'b1; mc_cycles_e = 4'd1;
        #1;
        checks++;
        if ({stall_f, stall_e, flush_m} !== 3'b000) begin
            errors++;
            $display("FAIL mc_single got %b want 000", {stall_f, stall_e, flush_m});
        end
        step();
        checks++;
        if (stall_e !== 1'b0 || stall_cnt !== 16'd8) begin
            errors++;
            $display("FAIL mc_single_next got stall_e=%b cnt=%0d want 0 and 8", stall_e, stall_cnt);
        end
        clear_inputs();
    endtask

    task automatic test_forwarding();
        reg_write_m = 1; reg_write_w = 1; rd_m = 7; rd_w = 7; rs1_e = 7;
        #1;
        checks++;
        if (fwd_a !== 2'b10) begin
            errors++;
            $display("FAIL fwd_a_mem got %b want 10", fwd_a);
        end
        reg_write_m = 0;
        #1;
        checks++;
        if (fwd_a !== 2'b01) begin
            errors++;
            $display("FAIL fwd_a_wb got %b want 01", fwd_a);
        end
        reg_write_m = 1; rd_m = 0; rd_w = 0; rs1_e = 0;
        #1;
        checks++;
        if (fwd_a !== 2'b00) begin
            errors++;
            $display("FAIL fwd_a_r0 got %b want 00", fwd_a);
        end
        rd_m = 5; rs2_e = 5; rd_w = 9; rs1_e = 9;
        #1;
        checks++;
        if ({fwd_a, fwd_b} !== 4'b0110) begin
            errors++;
            $display("FAIL fwd_ab got %b want 0110", {fwd_a, fwd_b});
        end
        reg_write_m = 0; rd_w = 5;
        #1;
        checks++;
        if ({fwd_a, fwd_b} !== 4'b0001) begin
            errors++;
            $display("FAIL fwd_b_wb got %b want 0001", {fwd_a, fwd_b});
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_mc();
        step();
        mc_start_e = 1'b1; mc_cycles_e = 4'd6;
        repeat (2) step();
        checks++;
        if (stall_e !== 1'b1) begin
            errors++;
            $display("FAIL mid_mc_wait got %b want 1", stall_e);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({stall_f, stall_e, flush_m, stall_cnt} !== {3'b000, 16'd0}) begin
            errors++;
            $display("FAIL mid_mc_reset got stalls=%b cnt=%0d want 000 and 0",
                     {stall_f, stall_e, flush_m}, stall_cnt);
        end
        clear_inputs();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_saturation();
        step();
        mem_read_e = 1'b1; rd_e = 4'd2; rs1_d = 4'd2;
        repeat (70000) @(posedge clk);
        step();
        checks++;
        if (stall_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_cnt got %h want ffff", stall_cnt);
        end
        repeat (3) step();
        checks++;
        if (stall_cnt !== 16'hFFFF || stall_f !== 1'b1) begin
            errors++;
            $display("FAIL sat_hold got cnt=%h stall_f=%b want ffff and 1", stall_cnt, stall_f);
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        step();
        test_load_use();
        test_branch();
        test_multicycle();
        test_forwarding();
        test_reset_mid_mc();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
